// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch datapath on the board clock.
// Counts up or down once per second, supports pause, lap freeze of the
// display, and per-field manual adjust with a blinking selected field.
module stopwatch_core #(
   parameter int CLK_HZ  = 100000000,
   parameter int ADJ_HZ  = 2,
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause_btn,
   input  logic       lap_btn,
   input  logic       sel,
   input  logic       adj,
   input  logic       cnt_dn,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] blank,
   output logic       paused,
   output logic       done,
   output logic       sec_tick
);

   localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
   localparam int SEC_W   = $clog2(CLK_HZ);
   localparam int ADJ_W   = $clog2(ADJ_DIV);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
   localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_DIV - 1);
   localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

   logic [SEC_W-1:0] sec_div;
   logic [ADJ_W-1:0] adj_div;
   logic             adj_tick;
   logic             pause_q, lap_q, pause_rise, lap_rise;
   logic             hold, hold_n, phase, phase_n;
   logic [3:0]       field_mask;

   // live time, separate from the (possibly frozen) displayed digits
   logic [3:0] t_mt, t_mo, t_st, t_so;

   logic [3:0] si_t, si_o, mi_t, mi_o;
   logic [3:0] up_mt, up_mo, up_st, up_so;
   logic [3:0] dn_mt, dn_mo, dn_st, dn_so;
   logic       sec_wrap, min_top, at_zero, dn_hits_zero;

   assign sec_tick   = (sec_div == SEC_LAST);
   assign adj_tick   = (adj_div == ADJ_LAST);
   assign pause_rise = pause_btn & ~pause_q;
   assign lap_rise   = lap_btn & ~lap_q & ~adj;
   // adjust clears lap hold; otherwise each lap press toggles it
   assign hold_n     = adj ? 1'b0 : (hold ^ lap_rise);
   // blink phase only advances while adjusting, and is parked at 0 outside
   assign phase_n    = adj ? (phase ^ adj_tick) : 1'b0;
   assign field_mask = sel ? 4'b0011 : 4'b1100;

   // BCD next-value candidates for up-count, down-count and field adjust
   always_comb begin
      sec_wrap     = (t_st == 4'd5) && (t_so == 4'd9);
      min_top      = (t_mt == MAX_T) && (t_mo == MAX_O);
      at_zero      = (t_mt == 4'd0) && (t_mo == 4'd0) && (t_st == 4'd0) && (t_so == 4'd0);
      dn_hits_zero = (t_mt == 4'd0) && (t_mo == 4'd0) && (t_st == 4'd0) && (t_so == 4'd1);

      // seconds +1 with no carry out: 59 -> 00
      si_o = (t_so == 4'd9) ? 4'd0 : t_so + 4'd1;
      si_t = (t_so != 4'd9) ? t_st : ((t_st == 4'd5) ? 4'd0 : t_st + 4'd1);

      // minutes +1 with no carry out: MAX_MIN -> 00
      if (min_top) begin
         mi_t = 4'd0;
         mi_o = 4'd0;
      end else if (t_mo == 4'd9) begin
         mi_t = t_mt + 4'd1;
         mi_o = 4'd0;
      end else begin
         mi_t = t_mt;
         mi_o = t_mo + 4'd1;
      end

      // up-count: minutes only step when seconds roll over
      up_so = si_o;
      up_st = si_t;
      up_mt = sec_wrap ? mi_t : t_mt;
      up_mo = sec_wrap ? mi_o : t_mo;

      // down-count: 00 seconds borrows a minute and becomes 59
      dn_so = (t_so == 4'd0) ? 4'd9 : t_so - 4'd1;
      dn_st = (t_so != 4'd0) ? t_st : ((t_st == 4'd0) ? 4'd5 : t_st - 4'd1);
      dn_mt = t_mt;
      dn_mo = t_mo;
      if ((t_st == 4'd0) && (t_so == 4'd0)) begin
         if (t_mo == 4'd0) begin
            dn_mo = 4'd9;
            dn_mt = t_mt - 4'd1;
         end else begin
            dn_mo = t_mo - 4'd1;
         end
      end
   end

   // dividers, button edges, mode state, live time and registered display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_div  <= '0;
         adj_div  <= '0;
         pause_q  <= 1'b0;
         lap_q    <= 1'b0;
         paused   <= 1'b0;
         hold     <= 1'b0;
         phase    <= 1'b0;
         blank    <= 4'b0000;
         done     <= 1'b0;
         t_mt     <= 4'd0;
         t_mo     <= 4'd0;
         t_st     <= 4'd0;
         t_so     <= 4'd0;
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
      end else begin
         sec_div <= sec_tick ? '0 : sec_div + SEC_W'(1);
         adj_div <= adj_tick ? '0 : adj_div + ADJ_W'(1);
         pause_q <= pause_btn;
         lap_q   <= lap_btn;
         if (pause_rise) paused <= ~paused;
         hold  <= hold_n;
         phase <= phase_n;
         blank <= phase_n ? field_mask : 4'b0000;

         // display follows live time except while a lap hold persists
         if (!(hold && hold_n))
            {min_tens, min_ones, sec_tens, sec_ones} <= {t_mt, t_mo, t_st, t_so};

         if (!cnt_dn) done <= 1'b0;

         if (adj) begin
            if (adj_tick) begin
               done <= 1'b0;
               if (sel) {t_st, t_so} <= {si_t, si_o};
               else     {t_mt, t_mo} <= {mi_t, mi_o};
            end
         end else if (sec_tick && !paused) begin
            // paused here is the pre-toggle value, so a same-cycle press still counts
            if (!cnt_dn) begin
               {t_mt, t_mo, t_st, t_so} <= {up_mt, up_mo, up_st, up_so};
            end else if (at_zero) begin
               done <= 1'b1;
            end else begin
               {t_mt, t_mo, t_st, t_so} <= {dn_mt, dn_mo, dn_st, dn_so};
               done <= dn_hits_zero;
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: scoreboard bench for stopwatch_core at CLK_HZ=20,
// ADJ_HZ=2, MAX_MIN=2. Expected displays come from an integer-seconds model.
module tb_stopwatch_core;

   localparam int CLK_HZ  = 20;
   localparam int ADJ_HZ  = 2;
   localparam int MAX_MIN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pause_btn = 1'b0;
   logic       lap_btn = 1'b0;
   logic       sel = 1'b0;
   logic       adj = 1'b0;
   logic       cnt_dn = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
   logic       paused, done, sec_tick;
   logic [15:0] disp;

   int checks = 0;
   int passes = 0;
   int tm = 0;
   logic [15:0] exp_q[$];

   assign disp = {min_tens, min_ones, sec_tens, sec_ones};

   always #5 clk = ~clk;

   stopwatch_core #(.CLK_HZ(CLK_HZ), .ADJ_HZ(ADJ_HZ), .MAX_MIN(MAX_MIN)) dut (
      .clk(clk), .rst(rst), .pause_btn(pause_btn), .lap_btn(lap_btn),
      .sel(sel), .adj(adj), .cnt_dn(cnt_dn),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .blank(blank), .paused(paused), .done(done), .sec_tick(sec_tick)
   );

   function automatic logic [15:0] to_bcd(input int t);
      int m, s;
      m = t / 60;
      s = t % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int step_up(input int t);
      return (t + 1) % ((MAX_MIN + 1) * 60);
   endfunction

   function automatic int step_dn(input int t);
      return (t == 0) ? 0 : t - 1;
   endfunction

   // wait for the negedge on which sec_tick is high
   task automatic sync_tick();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sec_tick === 1'b1) return;
      end
      checks++;
      $display("FAIL sync_tick: no sec_tick within 40 cycles");
   endtask

   // one tick plus the two edges needed for live time and display to update
   task automatic settle();
      sync_tick();
      repeat (2) @(negedge clk);
   endtask

   // adjust each field until it steps onto the target, then leave adjust
   task automatic load_time(input int m, input int s);
      logic [15:0] want;
      logic [7:0]  prev;
      bit          ok;
      want = to_bcd(m * 60 + s);
      adj = 1'b1;
      sel = 1'b0;
      repeat (2) @(negedge clk);
      prev = {min_tens, min_ones};
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge clk);
         if ({min_tens, min_ones} != prev && {min_tens, min_ones} == want[15:8]) ok = 1'b1;
         prev = {min_tens, min_ones};
      end
      if (!ok) begin
         checks++;
         $display("FAIL load_min: minutes %h never stepped to %h", {min_tens, min_ones}, want[15:8]);
      end
      sel = 1'b1;
      prev = {sec_tens, sec_ones};
      ok = 1'b0;
      for (int i = 0; i < 700 && !ok; i++) begin
         @(negedge clk);
         if ({sec_tens, sec_ones} != prev && {sec_tens, sec_ones} == want[7:0]) ok = 1'b1;
         prev = {sec_tens, sec_ones};
      end
      if (!ok) begin
         checks++;
         $display("FAIL load_sec: seconds %h never stepped to %h", {sec_tens, sec_ones}, want[7:0]);
      end
      if (sec_tick) @(negedge clk);
      adj = 1'b0;
      tm = m * 60 + s;
   endtask

   task automatic test_reset();
      logic [15:0] e;
      int pulses;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      load_time(1, 37);
      pause_btn = 1'b1;
      @(negedge clk);
      pause_btn = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (disp !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", disp); else passes++;
      checks++; if (blank !== 4'b0000) $display("FAIL reset_blank: got %b want 0000", blank); else passes++;
      checks++; if (paused !== 1'b0) $display("FAIL reset_paused: got %b want 0", paused); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
      checks++; if (sec_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", sec_tick); else passes++;
      @(negedge clk);
      rst = 1'b0;
      tm = 0;
      pulses = 0;
      tm = step_up(tm);
      exp_q.push_back(to_bcd(tm));
      repeat (20) begin
         @(negedge clk);
         if (sec_tick === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) $display("FAIL reset_tick_count: got %0d want 1", pulses); else passes++;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL reset_first_sec: got %h want %h", disp, e); else passes++;
   endtask

   task automatic test_up_wrap();
      logic [15:0] e;
      cnt_dn = 1'b0;
      load_time(2, 58);
      for (int i = 0; i < 2; i++) begin
         tm = step_up(tm);
         exp_q.push_back(to_bcd(tm));
         settle();
         e = exp_q.pop_front();
         checks++; if (disp !== e) $display("FAIL up_wrap_%0d: got %h want %h", i, disp, e); else passes++;
         checks++; if (done !== 1'b0) $display("FAIL up_wrap_done_%0d: got %b want 0", i, done); else passes++;
      end
      load_time(0, 59);
      tm = step_up(tm);
      exp_q.push_back(to_bcd(tm));
      settle();
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL up_min_carry: got %h want %h", disp, e); else passes++;
   endtask

   task automatic test_count_down();
      logic [15:0] e;
      logic        de;
      cnt_dn = 1'b1;
      load_time(0, 2);
      for (int i = 0; i < 5; i++) begin
         tm = step_dn(tm);
         de = (tm == 0);
         exp_q.push_back(to_bcd(tm));
         settle();
         e = exp_q.pop_front();
         checks++; if (disp !== e) $display("FAIL down_%0d: got %h want %h", i, disp, e); else passes++;
         checks++; if (done !== de) $display("FAIL down_done_%0d: got %b want %b", i, done, de); else passes++;
      end
      cnt_dn = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("FAIL down_done_clear: got %b want 0", done); else passes++;
      tm = step_up(tm);
      exp_q.push_back(to_bcd(tm));
      settle();
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL down_then_up: got %h want %h", disp, e); else passes++;
   endtask

   task automatic test_pause();
      logic [15:0] e;
      load_time(0, 5);
      sync_tick();
      pause_btn = 1'b1;
      tm = step_up(tm);
      exp_q.push_back(to_bcd(tm));
      @(negedge clk);
      pause_btn = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL pause_same_tick: got %h want %h", disp, e); else passes++;
      checks++; if (paused !== 1'b1) $display("FAIL pause_state: got %b want 1", paused); else passes++;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(to_bcd(tm));
         settle();
         e = exp_q.pop_front();
         checks++; if (disp !== e) $display("FAIL pause_frozen_%0d: got %h want %h", i, disp, e); else passes++;
         checks++; if (paused !== 1'b1) $display("FAIL pause_held_%0d: got %b want 1", i, paused); else passes++;
      end
      pause_btn = 1'b1;
      @(negedge clk);
      pause_btn = 1'b0;
      checks++; if (paused !== 1'b0) $display("FAIL pause_resume: got %b want 0", paused); else passes++;
      tm = step_up(tm);
      exp_q.push_back(to_bcd(tm));
      settle();
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL pause_counting: got %h want %h", disp, e); else passes++;
   endtask

   task automatic test_adjust();
      logic [15:0] e, prev;
      logic [3:0]  eb;
      int          mm, ss;
      bit          ph, ok;
      load_time(0, 58);
      @(negedge clk);
      checks++; if (blank !== 4'b0000) $display("FAIL adj_pre_blank: got %b want 0000", blank); else passes++;
      mm = 0;
      ss = 58;
      ph = 1'b0;
      adj = 1'b1;
      sel = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) sel = 1'b0;
         if (sel) ss = (ss + 1) % 60;
         else     mm = (mm + 1) % (MAX_MIN + 1);
         ph = ~ph;
         eb = ph ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
         exp_q.push_back(to_bcd(mm * 60 + ss));
         prev = disp;
         ok = 1'b0;
         for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (disp != prev) ok = 1'b1;
         end
         e = exp_q.pop_front();
         if (!ok) begin
            checks++;
            $display("FAIL adj_step_timeout_%0d: display stuck at %h want %h", i, disp, e);
         end
         checks++; if (disp !== e) $display("FAIL adj_step_%0d: got %h want %h", i, disp, e); else passes++;
         checks++; if (blank !== eb) $display("FAIL adj_blank_%0d: got %b want %b", i, blank, eb); else passes++;
      end
      adj = 1'b0;
      @(negedge clk);
      checks++; if (blank !== 4'b0000) $display("FAIL adj_exit_blank: got %b want 0000", blank); else passes++;
   endtask

   task automatic test_lap();
      logic [15:0] e;
      int          held;
      load_time(0, 10);
      lap_btn = 1'b1;
      held = tm;
      @(negedge clk);
      lap_btn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tm = step_up(tm);
         exp_q.push_back(to_bcd(held));
         settle();
         e = exp_q.pop_front();
         checks++; if (disp !== e) $display("FAIL lap_frozen_%0d: got %h want %h", i, disp, e); else passes++;
      end
      lap_btn = 1'b1;
      exp_q.push_back(to_bcd(tm));
      @(negedge clk);
      lap_btn = 1'b0;
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL lap_release: got %h want %h", disp, e); else passes++;
      tm = step_up(tm);
      exp_q.push_back(to_bcd(tm));
      settle();
      e = exp_q.pop_front();
      checks++; if (disp !== e) $display("FAIL lap_live: got %h want %h", disp, e); else passes++;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_count_down();
      test_pause();
      test_adjust();
      test_lap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
